// File: rtl/aes_spi_pkg.sv
// aes_spi_pkg
// Shared definitions for the AES SPI host and the slave-side driver:
// legal key lengths, fixed byte counts of a transaction, the host state
// encoding and small helpers for key-length checking and key byte selection.
package aes_spi_pkg;

    localparam logic [7:0] KEY_LEN_128 = 8'd16;
    localparam logic [7:0] KEY_LEN_192 = 8'd24;
    localparam logic [7:0] KEY_LEN_256 = 8'd32;

    localparam logic [4:0] DATA_BYTES  = 5'd16;
    localparam logic [4:0] PARAM_BYTES = 5'd1;
    localparam logic [4:0] RECV_BYTES  = 5'd16;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SEND_DATA  = 3'd1,
        ST_SEND_PARAM = 3'd2,
        ST_SEND_KEY   = 3'd3,
        ST_GAP        = 3'd4,
        ST_RECV       = 3'd5,
        ST_DONE       = 3'd6
    } state_t;

    function automatic logic key_len_legal(input logic [7:0] len);
        return (len == KEY_LEN_128) || (len == KEY_LEN_192) || (len == KEY_LEN_256);
    endfunction

    // Byte idx of the key stream, counting from the most significant used byte.
    // Only the low 5 bits of the length matter: 32 wraps to 0 and 0-1 gives 31.
    function automatic logic [7:0] key_byte(input logic [255:0] key,
                                            input logic [4:0]   len_lo,
                                            input logic [4:0]   idx);
        logic [4:0] sel;
        sel = len_lo - 5'd1 - idx;
        return key[{sel, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/aes_spi_host_byte.sv
// spi_master_byte
// Shifts one byte out on mosi (MSB first) while shifting one byte in from
// miso, SPI mode 0. Each sclk half-period is CLK_DIV clk cycles, so a byte
// takes 16*CLK_DIV cycles. If load is high when a byte ends, the next
// tx_byte is taken on the same edge so consecutive bytes run back-to-back.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   load        : a byte is waiting in tx_byte
//   tx_byte     : byte to send
//   taken       : one-cycle pulse, tx_byte was captured on the previous edge
//   done        : one-cycle pulse, a byte finished and rx_byte is valid
//   rx_byte     : last received byte
//   sclk, mosi  : SPI outputs (registered)
//   miso        : SPI input, sampled on the sclk rising edge
module spi_master_byte #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] tx_byte,
    output logic       taken,
    output logic       done,
    output logic [7:0] rx_byte,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic       active;
    logic [7:0] div_cnt;
    logic [3:0] half_cnt;
    logic [7:0] sh_tx;
    logic [7:0] sh_rx;

    // Half-period timing, bit shifting and back-to-back byte chaining.
    always_ff @(posedge clk) begin
        if (reset) begin
            active   <= 1'b0;
            div_cnt  <= 8'd0;
            half_cnt <= 4'd0;
            sh_tx    <= 8'd0;
            sh_rx    <= 8'd0;
            rx_byte  <= 8'd0;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            taken    <= 1'b0;
            done     <= 1'b0;
        end else begin
            taken <= 1'b0;
            done  <= 1'b0;
            if (active && (div_cnt != DIV_LAST)) begin
                div_cnt <= div_cnt + 8'd1;
            end else if (active && (half_cnt != 4'd15)) begin
                div_cnt  <= 8'd0;
                half_cnt <= half_cnt + 4'd1;
                if (!half_cnt[0]) begin
                    // rising edge: sample the slave
                    sclk  <= 1'b1;
                    sh_rx <= {sh_rx[6:0], miso};
                end else begin
                    // falling edge: present the next bit
                    sclk  <= 1'b0;
                    mosi  <= sh_tx[6];
                    sh_tx <= {sh_tx[6:0], 1'b0};
                end
            end else begin
                // idle, or the final half-period of a byte has just ended
                if (active) begin
                    done    <= 1'b1;
                    rx_byte <= sh_rx;
                end
                sclk     <= 1'b0;
                div_cnt  <= 8'd0;
                half_cnt <= 4'd0;
                if (load) begin
                    active <= 1'b1;
                    sh_tx  <= tx_byte;
                    mosi   <= tx_byte[7];
                    taken  <= 1'b1;
                end else begin
                    active <= 1'b0;
                    mosi   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/aes_spi_host.sv
// aes_spi_host
// Sends a plaintext block, the key length and the key to an SPI AES engine,
// waits CALC_GAP cycles for the engine to compute, then reads back 16 bytes
// of ciphertext. Byte-level SPI timing is delegated to spi_master_byte; this
// module only sequences bytes.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start               : one-cycle request, accepted when busy=0
//   plaintext, key      : block and right-aligned key, latched on start
//   key_len             : 16, 24 or 32; anything else pulses err
//   busy                : transaction in progress
//   result, result_valid: ciphertext and its one-cycle valid pulse
//   err                 : one-cycle pulse for a start with illegal key_len
//   cs_n, sclk, mosi    : SPI outputs; miso: SPI input
module aes_spi_host
    import aes_spi_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int CALC_GAP = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] plaintext,
    input  logic [255:0] key,
    input  logic [7:0]   key_len,
    output logic         busy,
    output logic [127:0] result,
    output logic         result_valid,
    output logic         err,
    output logic         cs_n,
    output logic         sclk,
    output logic         mosi,
    input  logic         miso
);

    // The gap is measured from the edge ending the last key byte to the edge
    // the first receive byte is loaded; done and load each add one cycle of
    // latency, so the counter starts at 3 instead of 1.
    localparam logic [15:0] GAP_TARGET = 16'(CALC_GAP);
    localparam logic [15:0] GAP_INIT   = 16'd3;

    state_t         state;
    logic           load;
    logic [7:0]     tx_byte;
    logic [4:0]     idx;
    logic [15:0]    gap_cnt;
    logic [127:0]   pt_sh;
    logic [255:0]   key_r;
    logic [7:0]     klen_r;
    logic [119:0]   rx_sh;
    logic           eng_taken;
    logic           eng_done;
    logic [7:0]     eng_rx;

    spi_master_byte #(.CLK_DIV(CLK_DIV)) u_byte (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .tx_byte (tx_byte),
        .taken   (eng_taken),
        .done    (eng_done),
        .rx_byte (eng_rx),
        .sclk    (sclk),
        .mosi    (mosi),
        .miso    (miso)
    );

    // Transaction sequencer: tx_byte always holds the next byte to send and
    // advances each time the byte engine reports it has taken one.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            cs_n         <= 1'b1;
            busy         <= 1'b0;
            result       <= 128'd0;
            result_valid <= 1'b0;
            err          <= 1'b0;
            load         <= 1'b0;
            tx_byte      <= 8'd0;
            idx          <= 5'd0;
            gap_cnt      <= 16'd0;
            pt_sh        <= 128'd0;
            key_r        <= 256'd0;
            klen_r       <= 8'd0;
            rx_sh        <= 120'd0;
        end else begin
            result_valid <= 1'b0;
            err          <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    state <= ST_IDLE;
                    if (start) begin
                        if (key_len_legal(key_len)) begin
                            state   <= ST_SEND_DATA;
                            cs_n    <= 1'b0;
                            busy    <= 1'b1;
                            load    <= 1'b1;
                            tx_byte <= plaintext[127:120];
                            pt_sh   <= {plaintext[119:0], 8'h00};
                            key_r   <= key;
                            klen_r  <= key_len;
                            idx     <= 5'd0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_SEND_DATA: begin
                    if (eng_taken) begin
                        if (idx == DATA_BYTES - 5'd1) begin
                            state   <= ST_SEND_PARAM;
                            tx_byte <= klen_r;
                            idx     <= 5'd0;
                        end else begin
                            tx_byte <= pt_sh[127:120];
                            pt_sh   <= {pt_sh[119:0], 8'h00};
                            idx     <= idx + 5'd1;
                        end
                    end
                end
                ST_SEND_PARAM: begin
                    if (eng_taken) begin
                        if (idx == PARAM_BYTES - 5'd1) begin
                            state   <= ST_SEND_KEY;
                            tx_byte <= key_byte(key_r, klen_r[4:0], 5'd0);
                            idx     <= 5'd0;
                        end else begin
                            idx <= idx + 5'd1;
                        end
                    end
                end
                ST_SEND_KEY: begin
                    if (eng_taken) begin
                        if ({3'b000, idx} == klen_r - 8'd1) begin
                            load <= 1'b0;
                        end else begin
                            tx_byte <= key_byte(key_r, klen_r[4:0], idx + 5'd1);
                            idx     <= idx + 5'd1;
                        end
                    end
                    // with nothing left to load, the next done is the last key byte
                    if (!load && eng_done) begin
                        state   <= ST_GAP;
                        gap_cnt <= GAP_INIT;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt >= GAP_TARGET) begin
                        state   <= ST_RECV;
                        load    <= 1'b1;
                        tx_byte <= 8'h00;
                        idx     <= 5'd0;
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end
                ST_RECV: begin
                    if (eng_done) begin
                        rx_sh <= {rx_sh[111:0], eng_rx};
                    end
                    if (eng_taken) begin
                        if (idx == RECV_BYTES - 5'd1) begin
                            load <= 1'b0;
                        end else begin
                            idx <= idx + 5'd1;
                        end
                    end
                    if (!load && eng_done) begin
                        state        <= ST_DONE;
                        cs_n         <= 1'b1;
                        busy         <= 1'b0;
                        result_valid <= 1'b1;
                        result       <= {rx_sh, eng_rx};
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cs_n  <= 1'b1;
                    busy  <= 1'b0;
                    load  <= 1'b0;
                end
            endcase
        end
    end

endmodule
